npc_mem_arbiter: RTL

- Shares the single NPC memory port between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Replaces the separate combinational fetch and load memory accesses with one sequenced port using valid/ready request handshakes and a single outstanding transaction.
- Round-robin (or fixed LSU-priority) arbitration, a response router and a response watchdog.
- Sits between the IFU/LSU and the memory adapter that wraps the pmem read/write DPI calls.

---
 rtl/npc_mem_pkg.sv | 18 +
 rtl/npc_mem_arbiter_if.sv | 57 +++++
 rtl/npc_rr_arb2.sv | 42 ++++
 rtl/npc_mem_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// Shared types for the NPC memory-port arbiter: FSM state, transaction owner and default widths.
package npc_mem_pkg;

    localparam int unsigned AddrWDefault = 32;
    localparam int unsigned DataWDefault = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    typedef enum logic {
        OwnIfu = 1'b0,
        OwnLsu = 1'b1
    } owner_e;

endpackage

// File: rtl/npc_mem_arbiter_if.sv
// Bundles the IFU, LSU and memory-side handshakes of the NPC memory arbiter.
interface npc_mem_arbiter_if
    import npc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) ();

    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_resp_valid;
    logic [DATA_W-1:0]     ifu_rdata;
    logic                  ifu_resp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  lsu_resp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output busy
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  busy
    );

endinterface

// File: rtl/npc_rr_arb2.sv
// Two-input IFU/LSU grant logic, round-robin or fixed LSU priority, with its last-grant flop.
module npc_rr_arb2
    import npc_mem_pkg::*;
#(
    parameter bit LSU_PRIORITY = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_ifu_i,
    input  logic req_lsu_i,
    input  logic accept_i,
    output logic gnt_ifu_o,
    output logic gnt_lsu_o
);

    owner_e last_q;

    always_comb begin
        gnt_ifu_o = 1'b0;
        gnt_lsu_o = 1'b0;
        if (req_ifu_i && req_lsu_i) begin
            // On a tie the requester that did not win last time goes next.
            if (LSU_PRIORITY || (last_q == OwnIfu)) begin
                gnt_lsu_o = 1'b1;
            end else begin
                gnt_ifu_o = 1'b1;
            end
        end else begin
            gnt_ifu_o = req_ifu_i;
            gnt_lsu_o = req_lsu_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= OwnLsu;
        end else if (accept_i) begin
            last_q <= gnt_lsu_o ? OwnLsu : OwnIfu;
        end
    end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares one NPC memory port between IFU and LSU: single outstanding transaction,
// registered memory request, response routing and a response watchdog.
module npc_mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = AddrWDefault,
    parameter int unsigned DATA_W       = DataWDefault,
    parameter bit          LSU_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic               clk,
    input  logic               rst,
    npc_mem_arbiter_if.slave   bus
);

    localparam int unsigned WdogW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_e              state_q;
    owner_e              owner_q;
    logic [WdogW-1:0]    wdog_q;

    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_wen_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W/8-1:0] mem_wmask_q;

    logic                ifu_resp_valid_q, ifu_resp_err_q;
    logic [DATA_W-1:0]   ifu_rdata_q;
    logic                lsu_resp_valid_q, lsu_resp_err_q;
    logic [DATA_W-1:0]   lsu_rdata_q;

    logic gnt_ifu, gnt_lsu, idle, ifu_ready, lsu_ready, accept, timeout;

    assign idle      = (state_q == StIdle);
    assign ifu_ready = idle && gnt_ifu;
    assign lsu_ready = idle && gnt_lsu;
    assign accept    = ifu_ready || lsu_ready;
    assign timeout   = (TIMEOUT_CYC != 0) && (wdog_q == WdogLast);

    npc_rr_arb2 #(
        .LSU_PRIORITY (LSU_PRIORITY)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_ifu_i (bus.ifu_req_valid),
        .req_lsu_i (bus.lsu_req_valid),
        .accept_i  (accept),
        .gnt_ifu_o (gnt_ifu),
        .gnt_lsu_o (gnt_lsu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            owner_q          <= OwnIfu;
            wdog_q           <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_err_q   <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
            lsu_rdata_q      <= '0;
        end else begin
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_err_q   <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
            lsu_rdata_q      <= '0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q         <= StReq;
                        mem_req_valid_q <= 1'b1;
                        if (gnt_lsu) begin
                            owner_q     <= OwnLsu;
                            mem_addr_q  <= bus.lsu_addr;
                            mem_wen_q   <= bus.lsu_wen;
                            mem_wdata_q <= bus.lsu_wdata;
                            mem_wmask_q <= bus.lsu_wmask;
                        end else begin
                            owner_q     <= OwnIfu;
                            mem_addr_q  <= bus.ifu_addr;
                            mem_wen_q   <= 1'b0;
                            mem_wdata_q <= '0;
                            mem_wmask_q <= '0;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_req_ready) begin
                        state_q         <= StResp;
                        mem_req_valid_q <= 1'b0;
                        wdog_q          <= '0;
                    end
                end
                StResp: begin
                    wdog_q <= wdog_q + 1'b1;
                    // A real response beats a simultaneous timeout.
                    if (bus.mem_resp_valid) begin
                        state_q <= StIdle;
                        if (owner_q == OwnLsu) begin
                            lsu_resp_valid_q <= 1'b1;
                            lsu_rdata_q      <= mem_wen_q ? '0 : bus.mem_rdata;
                        end else begin
                            ifu_resp_valid_q <= 1'b1;
                            ifu_rdata_q      <= bus.mem_rdata;
                        end
                    end else if (timeout) begin
                        state_q <= StIdle;
                        if (owner_q == OwnLsu) begin
                            lsu_resp_valid_q <= 1'b1;
                            lsu_resp_err_q   <= 1'b1;
                        end else begin
                            ifu_resp_valid_q <= 1'b1;
                            ifu_resp_err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ifu_req_ready  = ifu_ready;
    assign bus.lsu_req_ready  = lsu_ready;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.ifu_resp_err   = ifu_resp_err_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_resp_err   = lsu_resp_err_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wen        = mem_wen_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wmask      = mem_wmask_q;
    assign bus.busy           = !idle;

endmodule
